// File: rtl/dcr_bank.sv
// Double-buffered device control register bank: host-written staging copies,
// active copies latched at kernel launch, and an IDLE/LAUNCH/RUN dispatcher FSM.
module dcr_bank #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REGS   = 4,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 wr_en,
  input  logic [ADDR_WIDTH-1:0]                wr_addr,
  input  logic [DATA_WIDTH-1:0]                wr_data,
  input  logic                                 rd_en,
  input  logic [ADDR_WIDTH-1:0]                rd_addr,
  output logic [DATA_WIDTH-1:0]                rd_data,
  output logic                                 rd_valid,
  input  logic                                 done,
  output logic                                 launch,
  output logic                                 busy,
  output logic                                 err,
  output logic [(NUM_REGS-1)*DATA_WIDTH-1:0]   config_out,
  output logic [DATA_WIDTH-1:0]                thread_count
);

  typedef enum logic [1:0] {IDLE, LAUNCH, RUN} state_t;

  localparam logic [31:0] NUM_REGS_U = 32'(NUM_REGS);

  state_t                state;
  state_t                state_nxt;
  logic [DATA_WIDTH-1:0] staging [1:NUM_REGS-1];
  logic [DATA_WIDTH-1:0] active  [1:NUM_REGS-1];
  logic [DATA_WIDTH-1:0] rd_mux;
  logic                  ctl_wr;
  logic                  start_req;
  logic                  clr_req;
  logic                  addr_ok;
  logic                  start_ok;
  logic                  err_set;

  assign ctl_wr    = wr_en && (wr_addr == '0);
  assign start_req = ctl_wr && wr_data[0];
  assign clr_req   = ctl_wr && wr_data[1];
  assign addr_ok   = {{(32-ADDR_WIDTH){1'b0}}, wr_addr} < NUM_REGS_U;
  assign start_ok  = start_req && (state == IDLE);
  // A START that arrives while a kernel is in flight is dropped and flagged.
  assign err_set   = (start_req && (state != IDLE)) || (wr_en && !addr_ok);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, which is exactly what the staging->active copy needs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // NOTE: every output of a combinational block is defaulted first so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    busy      = 1'b0;
    unique case (state)
      IDLE:   if (start_req) state_nxt = LAUNCH;
      LAUNCH: begin
        launch    = 1'b1;
        busy      = 1'b1;
        state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: staging/active are small flop arrays, not RAM, so they take the
  // asynchronous reset like any other register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 1; k < NUM_REGS; k++) begin
        staging[k] <= '0;
        active[k]  <= '0;
      end
    end else begin
      for (int k = 1; k < NUM_REGS; k++) begin
        if (wr_en && (wr_addr == ADDR_WIDTH'(k))) staging[k] <= wr_data;
        if (start_ok)                             active[k]  <= staging[k];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     err <= 1'b0;
    else if (err_set) err <= 1'b1;
    else if (clr_req) err <= 1'b0;
  end

  // Address 0 reports live status; out-of-range reads return zero silently.
  always_comb begin
    rd_mux = '0;
    if (rd_addr == '0) begin
      rd_mux[0] = busy;
      rd_mux[1] = err;
    end
    for (int k = 1; k < NUM_REGS; k++) begin
      if (rd_addr == ADDR_WIDTH'(k)) rd_mux = staging[k];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= rd_mux;
    end
  end

  always_comb begin
    config_out = '0;
    for (int k = 1; k < NUM_REGS; k++) begin
      config_out[(k-1)*DATA_WIDTH +: DATA_WIDTH] = active[k];
    end
  end

  assign thread_count = active[1];

endmodule

// File: tb/tb_dcr_bank.sv
// Self-checking bench for dcr_bank: directed scenarios with literal expectations
// followed by randomized traffic compared every cycle against a behavioural model.
module tb_dcr_bank;

  localparam int DW = 8;
  localparam int NR = 4;
  localparam int AW = 3;

  logic              clk     = 1'b0;
  logic              reset_n = 1'b1;
  logic              wr_en   = 1'b0;
  logic [AW-1:0]     wr_addr = '0;
  logic [DW-1:0]     wr_data = '0;
  logic              rd_en   = 1'b0;
  logic [AW-1:0]     rd_addr = '0;
  logic              done    = 1'b0;
  logic [DW-1:0]     rd_data;
  logic              rd_valid;
  logic              launch;
  logic              busy;
  logic              err;
  logic [(NR-1)*DW-1:0] config_out;
  logic [DW-1:0]     thread_count;

  int total = 0;
  int bad   = 0;
  bit cmp_on = 1'b0;

  dcr_bank #(.DATA_WIDTH(DW), .NUM_REGS(NR), .ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .done         (done),
    .launch       (launch),
    .busy         (busy),
    .err          (err),
    .config_out   (config_out),
    .thread_count (thread_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: kernel age is -1 when no kernel exists, 0 in the
  // launch cycle, and counts up while the kernel runs.
  int          m_age;
  logic [DW-1:0] m_stg [0:NR-1];
  logic [DW-1:0] m_act [0:NR-1];
  logic        m_err;
  logic        m_rdv;
  logic [DW-1:0] m_rdd;
  logic        m_start;
  logic        m_clr;
  logic        m_seterr;

  assign m_start  = wr_en && (wr_addr == 0) && wr_data[0];
  assign m_clr    = wr_en && (wr_addr == 0) && wr_data[1];
  assign m_seterr = (wr_en && (wr_addr >= NR)) || (m_start && (m_age >= 0));

  function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a);
    if (a == 0)  return {6'b0, m_err, (m_age >= 0)};
    if (a < NR)  return m_stg[a[1:0]];
    return '0;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_age <= -1;
      m_err <= 1'b0;
      m_rdv <= 1'b0;
      m_rdd <= '0;
      for (int k = 0; k < NR; k++) begin
        m_stg[k] <= '0;
        m_act[k] <= '0;
      end
    end else begin
      if (wr_en && (wr_addr >= 1) && (wr_addr < NR)) m_stg[wr_addr[1:0]] <= wr_data;
      if (m_age < 0) begin
        if (m_start) begin
          m_age <= 0;
          for (int k = 0; k < NR; k++) m_act[k] <= m_stg[k];
        end
      end else if ((m_age == 0) || !done) begin
        m_age <= m_age + 1;
      end else begin
        m_age <= -1;
      end
      if (m_seterr)   m_err <= 1'b1;
      else if (m_clr) m_err <= 1'b0;
      m_rdv <= rd_en;
      if (rd_en) m_rdd <= m_read(rd_addr);
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      check("cyc_launch",   launch,       (m_age == 0));
      check("cyc_busy",     busy,         (m_age >= 0));
      check("cyc_err",      err,          m_err);
      check("cyc_rd_valid", rd_valid,     m_rdv);
      check("cyc_rd_data",  rd_data,      m_rdd);
      check("cyc_config",   config_out,   {m_act[3], m_act[2], m_act[1]});
      check("cyc_threads",  thread_count, m_act[1]);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a);
    rd_en = 1'b1; rd_addr = a;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_launch"}, launch,       0);
    check({tag, "_busy"},   busy,         0);
    check({tag, "_err"},    err,          0);
    check({tag, "_rdv"},    rd_valid,     0);
    check({tag, "_rdd"},    rd_data,      0);
    check({tag, "_cfg"},    config_out,   0);
    check({tag, "_tc"},     thread_count, 0);
  endtask

  initial begin
    #2 reset_n = 1'b0;
    #1 check_all_zero("reset");
    @(negedge clk);
    cmp_on  = 1'b1;
    reset_n = 1'b1;

    // Basic launch with staged configuration.
    wr(1, 8'h20);
    wr(2, 8'h05);
    wr(0, 8'h01);
    check("launch_pulse", launch, 1);
    check("launch_tc",    thread_count, 8'h20);
    check("launch_cfg2",  config_out[15:8], 8'h05);
    check("launch_busy",  busy, 1);
    tick();
    check("launch_once",  launch, 0);
    check("run_busy",     busy, 1);

    // Staging while running leaves active untouched.
    wr(1, 8'h40);
    check("run_tc_held",  thread_count, 8'h20);
    rd(1);
    check("stage_rb",     rd_data, 8'h40);
    check("stage_rbv",    rd_valid, 1);

    // START while busy is dropped and flags an error.
    wr(0, 8'h01);
    check("drop_err",     err, 1);
    check("drop_nolaunch", launch, 0);
    rd(0);
    check("status_rb",    rd_data, 8'h03);
    done = 1'b1; tick(); done = 1'b0;
    check("done_idle",    busy, 0);
    wr(0, 8'h02);
    check("clr_err",      err, 0);
    wr(0, 8'h01);
    check("relaunch",     launch, 1);
    check("relaunch_tc",  thread_count, 8'h40);
    tick();
    done = 1'b1; tick(); done = 1'b0;
    check("relaunch_idle", busy, 0);

    // Out-of-range write and read.
    wr(5, 8'h77);
    check("oor_err",      err, 1);
    check("oor_cfg",      config_out, 24'h000540);
    rd(5);
    check("oor_rd",       rd_data, 8'h00);
    check("oor_rdv",      rd_valid, 1);
    wr(0, 8'h02);

    // done outside RUN is ignored.
    done = 1'b1; tick(); done = 1'b0;
    check("idle_done_busy", busy, 0);
    check("idle_done_err",  err, 0);
    wr(0, 8'h01);
    done = 1'b1; tick(); done = 1'b0;
    check("launch_done_busy", busy, 1);
    tick(3);
    check("run_wait_busy", busy, 1);
    done = 1'b1; tick(); done = 1'b0;
    check("run_done_idle", busy, 0);

    // Read and write to the same address return the pre-write value.
    rd_en = 1'b1; rd_addr = 2; wr_en = 1'b1; wr_addr = 2; wr_data = 8'h99;
    tick();
    rd_en = 1'b0; wr_en = 1'b0;
    check("rw_same_old", rd_data, 8'h05);
    rd(2);
    check("rw_same_new", rd_data, 8'h99);

    // Asynchronous reset mid-RUN.
    wr(0, 8'h01);
    tick();
    #2 reset_n = 1'b0;
    #1 check_all_zero("midrun");
    @(negedge clk);
    reset_n = 1'b1;
    wr(0, 8'h01);
    check("post_rst_launch", launch, 1);
    check("post_rst_cfg",    config_out, 0);

    // START and CLR_ERR together: both act in IDLE; set wins while busy.
    tick();
    done = 1'b1; tick(); done = 1'b0;
    wr(6, 8'h00);
    check("err_set6",   err, 1);
    wr(0, 8'h03);
    check("start_clr_launch", launch, 1);
    check("start_clr_err",    err, 0);
    wr(0, 8'h03);
    check("set_wins",   err, 1);
    done = 1'b1; tick(); done = 1'b0;

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      wr_en   = ($urandom_range(0, 2) == 0);
      wr_addr = AW'($urandom_range(0, 7));
      wr_data = DW'($urandom);
      rd_en   = 1'($urandom_range(0, 1));
      rd_addr = AW'($urandom_range(0, 7));
      done    = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 399) == 0) begin
        #2 reset_n = 1'b0;
        #1 reset_n = 1'b1;
      end
      @(negedge clk);
    end
    wr_en = 1'b0; rd_en = 1'b0; done = 1'b0;
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dcr_bank.md
DCR_BANK -- requirements
Module: dcr_bank

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning the width of every register and of the data buses.
REQ-002 SHALL have parameter NUM_REGS, default 4, meaning the register count: address 0 is control/status and addresses 1..NUM_REGS-1 hold configuration; legal range 2..16.
REQ-003 SHALL have parameter ADDR_WIDTH, default 2, meaning the address width, where 2^ADDR_WIDTH >= NUM_REGS.
REQ-004 SHALL have port clk, input, 1 bit, meaning the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit, meaning reset, asynchronous and active-low.
REQ-006 SHALL have port wr_en, input, 1 bit, meaning write strobe.
REQ-007 SHALL have port wr_addr, input, ADDR_WIDTH bits, meaning write address.
REQ-008 SHALL have port wr_data, input, DATA_WIDTH bits, meaning write data.
REQ-009 SHALL have port rd_en, input, 1 bit, meaning read strobe.
REQ-010 SHALL have port rd_addr, input, ADDR_WIDTH bits, meaning read address.
REQ-011 SHALL have port rd_data, output, DATA_WIDTH bits, meaning registered read data.
REQ-012 SHALL have port rd_valid, output, 1 bit, meaning rd_data is valid this cycle.
REQ-013 SHALL have port done, input, 1 bit, meaning the dispatcher reports kernel completion.
REQ-014 SHALL have port launch, output, 1 bit, meaning a one-cycle kernel start pulse.
REQ-015 SHALL have port busy, output, 1 bit, meaning a kernel is in flight.
REQ-016 SHALL have port err, output, 1 bit, meaning a sticky protocol-error flag.
REQ-017 SHALL have port config_out, output, (NUM_REGS-1)*DATA_WIDTH bits, meaning the active configuration; register k occupies bits [k*DATA_WIDTH-1 : (k-1)*DATA_WIDTH].
REQ-018 SHALL have port thread_count, output, DATA_WIDTH bits, meaning an alias of active register 1.

Function
REQ-019 SHALL keep two copies of each config register: staging (written by the host) and active (drives config_out).
REQ-020 wr_en to an address in 1..NUM_REGS-1 SHALL update staging on the next edge in every FSM state, allowing the next kernel to be staged while the current one runs.
REQ-021 A write to address 0 SHALL decode wr_data bit0 as START and bit1 as CLR_ERR; all other bits are ignored.
REQ-022 The FSM SHALL have states IDLE, LAUNCH and RUN, and SHALL enter IDLE on reset.
REQ-023 IDLE->LAUNCH SHALL occur on a START write; on the same edge active <= staging for all registers.
REQ-024 If the START edge also writes staging, this is impossible (single write port); the copy SHALL use the staging values before that edge.
REQ-025 In LAUNCH, launch=1 for exactly one cycle and the FSM SHALL go to RUN unconditionally; done is ignored in LAUNCH.
REQ-026 In RUN, done=1 SHALL cause RUN->IDLE on that edge; otherwise the FSM SHALL stay in RUN.
REQ-027 busy SHALL be 1 in LAUNCH and RUN, and 0 in IDLE.
REQ-028 A START write while busy SHALL be dropped (no copy, no launch) and SHALL set err.
REQ-029 A write to address >= NUM_REGS SHALL be ignored and SHALL set err.
REQ-030 CLR_ERR SHALL clear err on the next edge; if an error-setting event occurs on the same edge, set wins.
REQ-031 START and CLR_ERR in one write while IDLE SHALL both take effect.
REQ-032 done outside RUN SHALL be ignored without error.
REQ-033 A read SHALL have 1-cycle latency: rd_data and rd_valid are registered from rd_en; rd_valid=0 when rd_en=0 and rd_data holds its last value.
REQ-034 Reading address 0 SHALL return {zeros, err, busy} with busy in bit0; addresses 1..NUM_REGS-1 SHALL return staging; out-of-range addresses SHALL return 0 without setting err.
REQ-035 A read and a write to the same address on one edge SHALL return the pre-write value.

Reset
REQ-036 While reset_n=0, asynchronously: all staging and active registers = 0, FSM = IDLE, launch=0, busy=0, err=0, rd_data=0, rd_valid=0.
REQ-037 Reset during LAUNCH or RUN SHALL abort with no launch pulse; the first valid START after reset release SHALL launch normally.

Verification
REQ-038 Write reg1=0x20 and reg2=0x05, then write addr0=0x01 -> launch pulse 1 cycle later, thread_count=0x20, config_out[15:8]=0x05, busy=1 until done.
REQ-039 While RUN, write reg1=0x40 -> thread_count stays 0x20, readback of addr1=0x40; after done and a new START -> thread_count=0x40.
REQ-040 START while busy -> no second launch, err=1, read addr0=0x03; write addr0=0x02 -> err=0.
REQ-041 Write addr 5 with NUM_REGS=4 and ADDR_WIDTH=3 -> no state change except err=1; read addr 5 -> 0x00 with rd_valid=1.
REQ-042 Assert reset_n=0 mid-RUN -> all outputs 0 immediately; after release, START -> launch with active=0x00.
REQ-043 done pulsed in IDLE and in LAUNCH -> ignored, FSM reaches RUN and needs a later done to return to IDLE.
